// File: rtl/clk_freq_meter_pkg.sv
// Shared types and default sizing for the clock frequency meter.
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } fm_state_t;

  localparam int GATE_CYCLES_DEF = 1000;
  localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      q    <= 1'b0;
    end else begin
      r_s1 <= d;
      q    <= r_s1;
    end
  end

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous clock over a fixed window of clk cycles.
// Define CLK_FREQ_METER_CONT_EN for back-to-back windows after a single start.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             meas_clk,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  fm_state_t        r_state;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf_int;
  logic             r_s3;
  logic             w_s2;
  logic             w_edge;
  logic [CNT_W-1:0] w_edge_cnt_nxt;
  logic             w_ovf_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (meas_clk),
    .q     (w_s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s3 <= 1'b0;
    else        r_s3 <= w_s2;
  end

  assign w_edge = w_s2 & ~r_s3;

  // Saturating edge count including the current cycle, so the final gate cycle is captured.
  always_comb begin
    w_edge_cnt_nxt = r_edge_cnt;
    w_ovf_nxt      = r_ovf_int;
    if (w_edge) begin
      if (r_edge_cnt == CNT_MAX) w_ovf_nxt = 1'b1;
      else                       w_edge_cnt_nxt = r_edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_int  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= GATE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
            busy       <= 1'b1;
          end
        end
        GATE: begin
          r_gate_cnt <= r_gate_cnt + 1'b1;
          r_edge_cnt <= w_edge_cnt_nxt;
          r_ovf_int  <= w_ovf_nxt;
          if (r_gate_cnt == GATE_LAST) begin
            r_state  <= DONE;
            done     <= 1'b1;
            count    <= w_edge_cnt_nxt;
            overflow <= w_ovf_nxt;
          end
        end
        DONE: begin
`ifdef CLK_FREQ_METER_CONT_EN
          r_state    <= GATE;
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_ovf_int  <= 1'b0;
`else
          r_state <= IDLE;
          busy    <= 1'b0;
`endif
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
